// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider.
// Each channel has a divisor that can be reloaded at run time, a toggle or
// pulse output mode, and a terminal-count tick. A shared valid/ready port
// loads new divisors, one pending value per channel.

// One divider channel: counter, divisor, shadow register and registered outputs.
module clock_divider_ch #(
   parameter int CNT_W   = 25,
   parameter int DEF_DIV = 10000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             mode,
   input  logic             accept,
   input  logic [CNT_W-1:0] load_val,
   output logic             pend,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] shadow;
   logic             clk_int;
   logic             term;
   logic             div_upd;

   // >= rather than == so that a divisor shrinking below the held count
   // (possible while frozen) still terminates on the next enabled cycle.
   assign term = (cnt >= div);

   // A pending divisor is committed at a terminal count, while frozen, or on sync.
   // The old divisor still decides the terminal on which it is swapped in.
   assign div_upd = pend & (sync | ~en | term);

   // Counter, internal phase and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         clk_int <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (sync) begin
         cnt     <= '0;
         clk_int <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (!en) begin
         tick    <= 1'b0;
      end else if (term) begin
         cnt     <= '0;
         tick    <= 1'b1;
         clk_int <= ~clk_int;
         // Pulse mode is high on the terminal edge; toggle mode follows the new phase.
         clk_out <= mode | ~clk_int;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         tick    <= 1'b0;
         clk_out <= ~mode & clk_int;
      end
   end

   // Divisor, shadow register and pending flag.
   // An accept only happens with pend low, so it never collides with a commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div    <= CNT_W'(DEF_DIV);
         shadow <= '0;
         pend   <= 1'b0;
      end else begin
         if (div_upd) begin
            div <= shadow;
         end
         if (accept) begin
            shadow <= load_val;
            pend   <= 1'b1;
         end else if (div_upd) begin
            pend   <= 1'b0;
         end
      end
   end

endmodule

// Top level: channel array plus the shared load handshake.
module clock_divider_multi #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int CNT_W   = 25,
   parameter int DEF_DIV = 10000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sync,
   input  logic [NUM_CH-1:0] mode,
   input  logic              load_valid,
   input  logic [CH_W-1:0]   load_sel,
   input  logic [CNT_W-1:0]  load_val,
   output logic              load_ready,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0]       pend;
   logic [(1<<CH_W)-1:0]    pend_ext;
   logic [NUM_CH-1:0]       accept;

   // Zero-pad the pending flags so unused channel numbers always read ready
   // and their loads are accepted and dropped.
   always_comb begin
      pend_ext             = '0;
      pend_ext[NUM_CH-1:0] = pend;
   end

   assign load_ready = ~pend_ext[load_sel];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign accept[i] = load_valid & load_ready & (load_sel == CH_W'(i));

      clock_divider_ch #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en),
         .sync     (sync),
         .mode     (mode[i]),
         .accept   (accept[i]),
         .load_val (load_val),
         .pend     (pend[i]),
         .clk_out  (clk_out[i]),
         .tick     (tick[i])
      );
   end

endmodule
